// File: rtl/uart_pkg.sv
// Shared types and constants for the UART packet deframer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CHK  = 2'b10;
  localparam logic [1:0] ERR_OVF  = 2'b11;

  localparam logic [7:0] DEF_SOF = 8'hA5;

endpackage

// File: rtl/uart_byte_fifo.sv
// Shift-register FIFO; entry 0 is always the head, so o_head comes straight from a flop.
// Latency: a push into an empty FIFO is visible at o_head/!o_empty after one clk edge.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module uart_byte_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_cnt;
  logic             w_pop;
  logic             w_push;
  logic [CW-1:0]    w_widx;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_head  = r_mem[0];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  // on a simultaneous pop the new entry lands one slot lower, after the shift
  assign w_widx  = w_pop ? (r_cnt - CW'(1)) : r_cnt;

  // storage shift on pop, write at tail on push, occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_cnt <= '0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
      end
      if (w_push) r_mem[w_widx[AW-1:0]] <= i_din;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/uart_pkt_deframer.sv
// Deframes SOF,LEN,payload,CHK from a UART byte stream; payload streams out before the checksum verdict.
// Latency: payload byte strobe to m_valid is 1 clk (FIFO empty); rx_done edge to strobe is 2 clk (synchronizer).
// Backpressure: m_ready stalls the output FIFO; payload bytes arriving while full are dropped and the frame fails.
// Optional inter-byte timeout enabled by defining DEFRAMER_TIMEOUT_EN.
module uart_pkt_deframer
  import uart_pkg::*;
#(
  parameter logic [7:0] SOF         = DEF_SOF,
  parameter int         MAX_LEN     = 16,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         TIMEOUT_CYC = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_last,
  input  logic       m_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

  logic [1:0] r_sync;
  logic [1:0] r_fill;
  logic       r_prev;
  logic       r_armed;
  state_t     r_state;
  logic [7:0] r_rem;
  logic [7:0] r_xor;
  logic       r_ovf;

  logic       w_strobe;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic       w_in_pay;
  logic       w_push;
  logic       w_drop;
  logic       w_last;
  logic       w_tmo_hit;
  logic [8:0] w_head;

  // r_fill marks when r_sync[1] holds a real sample; r_armed needs one real low
  // sample, so rx_done already high at reset release cannot look like an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b00;
      r_fill  <= 2'b00;
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], rx_done};
      r_fill <= {r_fill[0], 1'b1};
      r_prev <= r_sync[1];
      if (r_fill[1] && !r_sync[1]) r_armed <= 1'b1;
    end
  end

  // rx_data is long stable by the time the synchronized edge shows up
  assign w_strobe = r_armed & r_sync[1] & ~r_prev;

  assign w_pop    = m_valid & m_ready;
  assign w_in_pay = w_strobe && (r_state == ST_PAYLOAD);
  assign w_push   = w_in_pay && (!w_full || w_pop);
  assign w_drop   = w_in_pay && w_full && !w_pop;
  assign w_last   = (r_rem == 8'd1);

  uart_byte_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   ({w_last, rx_data}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign m_valid = ~w_empty;
  assign m_last  = w_head[8];
  assign m_data  = w_head[7:0];

`ifdef DEFRAMER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_tmo;

  // idle-cycle counter, restarted by every byte and parked while hunting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (w_strobe || r_state == ST_HUNT) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + TW'(1);
    end
  end

  assign w_tmo_hit = (r_state != ST_HUNT) && (r_tmo == TW'(TIMEOUT_CYC - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYC > 0);
  assign w_tmo_hit    = 1'b0;
`endif

  // frame FSM with registered verdict pulses and sticky error cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_HUNT;
      r_rem     <= 8'd0;
      r_xor     <= 8'd0;
      r_ovf     <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (w_strobe) begin
        case (r_state)
          ST_HUNT: begin
            if (rx_data == SOF) begin
              r_state <= ST_LEN;
              r_ovf   <= 1'b0;
            end
          end
          ST_LEN: begin
            if (rx_data == 8'd0 || rx_data > MAX_LEN8) begin
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
              r_state   <= ST_HUNT;
            end else begin
              r_rem   <= rx_data;
              r_xor   <= rx_data;
              r_state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            r_xor <= r_xor ^ rx_data;
            r_rem <= r_rem - 8'd1;
            if (w_drop) r_ovf <= 1'b1;
            if (w_last) r_state <= ST_CHECK;
          end
          ST_CHECK: begin
            if (r_ovf) begin
              frame_err <= 1'b1;
              err_code  <= ERR_OVF;
            end else if (rx_data != r_xor) begin
              frame_err <= 1'b1;
              err_code  <= ERR_CHK;
            end else begin
              frame_ok <= 1'b1;
            end
            r_state <= ST_HUNT;
          end
          default: r_state <= ST_HUNT;
        endcase
      end else if (w_tmo_hit) begin
        frame_err <= 1'b1;
        err_code  <= ERR_OVF;
        r_state   <= ST_HUNT;
      end
    end
  end

endmodule

// File: tb/tb_uart_pkt_deframer.sv
// Directed bench for uart_pkt_deframer (default build, timeout disabled).
// Latency: bytes are driven as 4-cycle rx_done pulses separated by 4 low cycles.
// Backpressure: m_ready toggled to exercise FIFO overflow and drain.
module tb_uart_pkt_deframer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  int total = 0;
  int bad   = 0;
  int ok_cnt  = 0;
  int err_cnt = 0;
  int both_seen = 0;
  int ok0;
  int err0;
  logic [8:0] q[$];

  always #5 clk = ~clk;

  uart_pkt_deframer #(
    .SOF         (8'hA5),
    .MAX_LEN     (16),
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (2000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code)
  );

  // record accepted output beats and verdict pulses away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) q.push_back({m_last, m_data});
      if (frame_ok) ok_cnt++;
      if (frame_err) err_cnt++;
      if (frame_ok && frame_err) both_seen++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    cycles(4);
    rx_done = 1'b0;
    cycles(4);
  endtask

  task automatic mark();
    q.delete();
    ok0  = ok_cnt;
    err0 = err_cnt;
  endtask

  initial begin
    rst_n   = 1'b0;
    rx_done = 1'b1;
    rx_data = 8'hA5;
    m_ready = 1'b1;
    cycles(3);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_frame_ok", frame_ok, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_err_code", err_code, 0);

    // SOF held on rx_done across release must not start a frame:
    // a following 00 would otherwise be taken as a bad length
    rst_n = 1'b1;
    cycles(10);
    rx_done = 1'b0;
    cycles(6);
    mark();
    send_byte(8'h00);
    cycles(4);
    chk("no_strobe_at_release", err_cnt - err0, 0);

    // good frame: checksum 03 = 03^11^22^33
    mark();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
    cycles(6);
    chk("f1_count", q.size(), 3);
    chk("f1_b0", q[0], 9'h011);
    chk("f1_b1", q[1], 9'h022);
    chk("f1_b2", q[2], 9'h133);
    chk("f1_ok", ok_cnt - ok0, 1);
    chk("f1_err", err_cnt - err0, 0);

    // bad checksum (correct would be 32): payload still streams
    mark();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
    send_byte(8'h20); send_byte(8'hFF);
    cycles(6);
    chk("f2_count", q.size(), 2);
    chk("f2_b0", q[0], 9'h010);
    chk("f2_b1", q[1], 9'h120);
    chk("f2_ok", ok_cnt - ok0, 0);
    chk("f2_err", err_cnt - err0, 1);
    chk("f2_code", err_code, 2'b10);

    // zero length, then 17 > MAX_LEN
    mark();
    send_byte(8'hA5); send_byte(8'h00);
    send_byte(8'hA5); send_byte(8'h11);
    cycles(6);
    chk("f3_err", err_cnt - err0, 2);
    chk("f3_code", err_code, 2'b01);
    chk("f3_no_valid", q.size(), 0);
    chk("f3_m_valid", m_valid, 0);

    // overflow with consumer stalled; first payload byte also checks latency
    m_ready = 1'b0;
    mark();
    send_byte(8'hA5); send_byte(8'h06);
    rx_data = 8'h01;
    rx_done = 1'b1;
    cycles(2);
    chk("lat_before", m_valid, 0);
    cycles(1);
    chk("lat_after", m_valid, 1);
    cycles(1);
    rx_done = 1'b0;
    cycles(4);
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h01);
    cycles(6);
    chk("f4_err", err_cnt - err0, 1);
    chk("f4_ok", ok_cnt - ok0, 0);
    chk("f4_code", err_code, 2'b11);
    chk("f4_held", m_valid, 1);
    m_ready = 1'b1;
    cycles(10);
    chk("f4_count", q.size(), 4);
    chk("f4_b0", q[0], 9'h001);
    chk("f4_b1", q[1], 9'h002);
    chk("f4_b2", q[2], 9'h003);
    chk("f4_b3", q[3], 9'h004);
    chk("f4_empty", m_valid, 0);

    // reset in the middle of a frame, with a byte parked in the FIFO
    m_ready = 1'b0;
    mark();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    chk("mid_buffered", m_valid, 1);
    rst_n = 1'b0;
    cycles(3);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_code", err_code, 0);
    rst_n = 1'b1;
    m_ready = 1'b1;
    cycles(20);
    chk("mid_no_err", err_cnt - err0, 0);
    chk("mid_no_data", q.size(), 0);

    // junk ahead of a one-byte frame: checksum 7F = 01^7E
    mark();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    cycles(6);
    chk("f5_count", q.size(), 1);
    chk("f5_b0", q[0], 9'h17E);
    chk("f5_ok", ok_cnt - ok0, 1);
    chk("f5_err", err_cnt - err0, 0);

    chk("ok_err_exclusive", both_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
